// File: rtl/processor_pkg.sv
// Shared processor definitions: stage and halt-cause encodings,
// sequencer state type and one-hot opcode index constants.
package processor_pkg;

    localparam logic [1:0] STAGE_FETCH     = 2'd0;
    localparam logic [1:0] STAGE_DECODE    = 2'd1;
    localparam logic [1:0] STAGE_EXECUTE   = 2'd2;
    localparam logic [1:0] STAGE_WRITEBACK = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_DECODE   = 2'd1,
        CAUSE_STALL    = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } halt_cause_e;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALTED    = 3'd4
    } seq_state_e;

    localparam int OPCODE_W = 11;

    localparam int ONEHOT_LUI_INDEX    = 0;
    localparam int ONEHOT_AUIPC_INDEX  = 1;
    localparam int ONEHOT_JAL_INDEX    = 2;
    localparam int ONEHOT_JALR_INDEX   = 3;
    localparam int ONEHOT_BRANCH_INDEX = 4;
    localparam int ONEHOT_LOAD_INDEX   = 5;
    localparam int ONEHOT_STORE_INDEX  = 6;
    localparam int ONEHOT_OP_IMM_INDEX = 7;
    localparam int ONEHOT_OP_INDEX     = 8;
    localparam int ONEHOT_FENCE_INDEX  = 9;
    localparam int ONEHOT_SYSTEM_INDEX = 10;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Ports: clk, reset (sync, active-high), inc (count strobe), value (count).
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/pipeline_sequencer.sv
// Four-stage instruction loop sequencer with stall handling, commit
// registers, sticky halt and debug counters.
// Ports: clk/reset; run, mem_stall_request, id/ex decode errors, writeback
// bundle in; stage, one-hot enables, advance, PC, rd write port, halt
// status, retired_count and stall_cycles out.
module pipeline_sequencer
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                mem_stall_request,
    input  logic                id_decoding_error,
    input  logic [OPCODE_W-1:0] ex_decoding_errors,
    input  logic [OPCODE_W-1:0] wb_opcode_selection,
    input  logic [31:0]         new_program_counter,
    input  logic                wb_rd_write_enabled,
    input  logic [4:0]          wb_rd_index,
    input  logic [31:0]         wb_rd_write_value,
    output logic [1:0]          stage,
    output logic                fetch_enable,
    output logic                decode_enable,
    output logic                execute_enable,
    output logic                writeback_enable,
    output logic                advance,
    output logic [31:0]         program_counter,
    output logic                rd_write_enabled,
    output logic [4:0]          rd_index,
    output logic [31:0]         rd_write_value,
    output logic                halted,
    output logic [1:0]          halt_cause,
    output logic [31:0]         retired_count,
    output logic [15:0]         stall_cycles
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    halt_cause_e r_halt_cause;
    halt_cause_e w_cause_nxt;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] w_stall_cnt_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_retired;
    logic        r_rd_we;
    logic [4:0]  r_rd_index;
    logic [31:0] r_rd_value;
    logic        w_commit;
    logic        w_stall_inc;
    logic        w_wb_err;
    logic        w_halted;

    assign w_wb_err = |(ex_decoding_errors & wb_opcode_selection);
    assign w_halted = (r_state == S_HALTED);

    always_comb begin
        w_state_nxt     = r_state;
        w_cause_nxt     = r_halt_cause;
        w_stall_cnt_nxt = r_stall_cnt;
        w_commit        = 1'b0;
        w_stall_inc     = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (run) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (id_decoding_error) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_DECODE;
                end else begin
                    w_state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (mem_stall_request) begin
                    w_stall_inc     = 1'b1;
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                    // This stall cycle is the one that reaches the limit.
                    if (r_stall_cnt == CW'(STALL_TIMEOUT - 1)) begin
                        w_state_nxt = S_HALTED;
                        w_cause_nxt = CAUSE_STALL;
                    end
                end else begin
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                if (w_wb_err) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_DECODE;
                end else if (new_program_counter[1:0] != 2'b00) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = CAUSE_MISALIGN;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_HALTED;
                w_cause_nxt = CAUSE_DECODE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_halt_cause <= CAUSE_NONE;
            r_stall_cnt  <= '0;
            r_pc         <= RESET_VECTOR;
            r_retired    <= '0;
            r_rd_we      <= 1'b0;
            r_rd_index   <= '0;
            r_rd_value   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            // Write strobe lives only for the FETCH cycle after a commit.
            r_rd_we      <= 1'b0;
            if (w_commit) begin
                r_pc       <= new_program_counter;
                r_rd_index <= wb_rd_index;
                r_rd_value <= wb_rd_write_value;
                r_rd_we    <= wb_rd_write_enabled && (wb_rd_index != 5'd0);
                r_retired  <= r_retired + 32'd1;
            end
        end
    end

    saturating_counter #(
        .WIDTH(16)
    ) u_stall_cycles (
        .clk  (clk),
        .reset(reset),
        .inc  (w_stall_inc),
        .value(stall_cycles)
    );

    assign stage            = w_halted ? STAGE_WRITEBACK : r_state[1:0];
    assign fetch_enable     = (r_state == S_FETCH);
    assign decode_enable    = (r_state == S_DECODE);
    assign execute_enable   = (r_state == S_EXECUTE);
    assign writeback_enable = (r_state == S_WRITEBACK);
    assign advance          = !w_halted
                            && !((r_state == S_EXECUTE) && mem_stall_request)
                            && !((r_state == S_FETCH) && !run);

    assign program_counter  = r_pc;
    assign rd_write_enabled = r_rd_we;
    assign rd_index         = r_rd_index;
    assign rd_write_value   = r_rd_value;
    assign halted           = w_halted;
    assign halt_cause       = r_halt_cause;
    assign retired_count    = r_retired;

endmodule
